// File: rtl/boid_plotter.sv
// ---------------------------------------------------------------------------
// boid_plotter
//   Per-frame draw sequencer feeding a double-buffered 1-bit framebuffer.
//   A frame tick toggles the buffer select, runs one full clear sweep of the
//   back buffer, and streams every boid's (x, y) from the position memory into
//   pixel writes. Boids outside the framebuffer are clipped and counted.
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous, active-high
//   frame_start    one-cycle frame tick
//   boid_idx       read address into the boid position memory
//   boid_x/boid_y  boid coordinates, one cycle after boid_idx
//   fb_we          framebuffer write enable
//   fb_write_addr  pixel address {y, x}; 0 when fb_we is low
//   fb_write_data  pixel value, always 1
//   fb_swap        one-cycle buffer-toggle pulse
//   fb_clear       clear-sweep enable, held for one full buffer sweep
//   busy           high from the swap cycle through frame_done
//   frame_done     one-cycle pulse when plot and clear are both finished
//   clip_count     clipped boids in the current/last frame, saturating
//   overrun        sticky flag: frame tick arrived while busy
// ---------------------------------------------------------------------------
module boid_plotter #(
  parameter int NUM_BOIDS      = 16,
  parameter int BOID_IDX_WIDTH = 4,
  parameter int COORD_WIDTH    = 8,
  parameter int FB_W_LOG2      = 5,
  parameter int FB_H_LOG2      = 5,
  parameter int ADDR_WIDTH     = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_start,
  output logic [BOID_IDX_WIDTH-1:0] boid_idx,
  input  logic [COORD_WIDTH-1:0]    boid_x,
  input  logic [COORD_WIDTH-1:0]    boid_y,
  output logic                      fb_we,
  output logic [ADDR_WIDTH-1:0]     fb_write_addr,
  output logic                      fb_write_data,
  output logic                      fb_swap,
  output logic                      fb_clear,
  output logic                      busy,
  output logic                      frame_done,
  output logic [7:0]                clip_count,
  output logic                      overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SWAP = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [BOID_IDX_WIDTH-1:0] LAST_IDX = BOID_IDX_WIDTH'(NUM_BOIDS - 1);

  state_t                  state;
  state_t                  state_nxt;

  logic                    vld_p0;
  logic                    vld_p1;
  logic                    vld_p2;

  logic [ADDR_WIDTH-1:0]   clear_cnt;
  logic                    clear_done;

  logic                    clip_p1;
  logic [ADDR_WIDTH-1:0]   addr_p1;
  logic                    run_empty;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The frame ends only once the clear sweep is exhausted and no boid is
  // still in flight anywhere in the plot pipeline.
  assign run_empty = clear_done && !vld_p0 && !vld_p1 && !vld_p2;

  always_comb begin
    state_nxt  = state;
    fb_swap    = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) state_nxt = SWAP;
      end
      SWAP: begin
        fb_swap   = 1'b1;
        busy      = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (run_empty) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fb_write_data = 1'b1;

  // Clip test looks only at the coordinate bits above the framebuffer size.
  always_comb begin
    clip_p1 = ((boid_x >> FB_W_LOG2) != '0) || ((boid_y >> FB_H_LOG2) != '0);
    addr_p1 = {boid_y[FB_H_LOG2-1:0], boid_x[FB_W_LOG2-1:0]};
  end

  // ---- clear engine ----
  // The framebuffer restarts its sweep whenever the enable drops, so the
  // enable is held without a break for exactly 2^ADDR_WIDTH cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      fb_clear   <= 1'b0;
      clear_cnt  <= '0;
      clear_done <= 1'b0;
    end else if (state == SWAP) begin
      fb_clear   <= 1'b1;
      clear_cnt  <= '0;
      clear_done <= 1'b0;
    end else if (fb_clear) begin
      if (clear_cnt == '1) begin
        fb_clear   <= 1'b0;
        clear_done <= 1'b1;
      end else begin
        clear_cnt <= clear_cnt + 1'b1;
      end
    end
  end

  // ---- S0: boid index issue ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0   <= 1'b0;
      boid_idx <= '0;
    end else if (state == SWAP) begin
      vld_p0   <= 1'b1;
      boid_idx <= '0;
    end else if (vld_p0) begin
      if (boid_idx == LAST_IDX) begin
        vld_p0 <= 1'b0;
      end else begin
        boid_idx <= boid_idx + 1'b1;
      end
    end
  end

  // ---- S1: coordinates on the bus, clip decided; S2: write or count ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1        <= 1'b0;
      vld_p2        <= 1'b0;
      fb_we         <= 1'b0;
      fb_write_addr <= '0;
    end else begin
      vld_p1        <= vld_p0;
      vld_p2        <= vld_p1;
      fb_we         <= vld_p1 && !clip_p1;
      fb_write_addr <= (vld_p1 && !clip_p1) ? addr_p1 : '0;
    end
  end

  // ---- status ----
  always_ff @(posedge clk) begin
    if (reset) begin
      clip_count <= '0;
      overrun    <= 1'b0;
    end else begin
      if (state == IDLE && frame_start) begin
        clip_count <= '0;
      end else if (vld_p1 && clip_p1) begin
        clip_count <= sat_inc(clip_count);
      end
      // A tick on the frame_done edge still sees a busy block and is dropped.
      if (frame_start && state != IDLE) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
